control_fsm: RTL

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/ctrl_pkg.sv | 94 +++++++++
 rtl/ctrl_decode.sv | 115 +++++++++++
 rtl/control_fsm.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: state encodings, opcodes,
// ALU operation codes, datapath mux-select codes and the control output bundle.
package ctrl_pkg;

  // State encodings (also driven on state_dbg).
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_WB_ALU   = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_WB_MEM   = 4'd7;
  localparam logic [3:0] S_MEM_WR   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_LHI      = 4'd11;
  localparam logic [3:0] S_MULTI    = 4'd12;
  localparam logic [3:0] S_HALT     = 4'd13;

  // Opcodes, instr[15:12].
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADI  = 4'b0001;
  localparam logic [3:0] OP_NDU  = 4'b0010;
  localparam logic [3:0] OP_LHI  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_LM   = 4'b0110;
  localparam logic [3:0] OP_SM   = 4'b0111;
  localparam logic [3:0] OP_JAL  = 4'b1000;
  localparam logic [3:0] OP_BEQ  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_NAND = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  // Memory address source.
  localparam logic [1:0] IORD_PC  = 2'd0;
  localparam logic [1:0] IORD_ALU = 2'd1;
  // PC (R7) load source: hold, R7-1+sext6, R7-1+sext9, ALU result.
  localparam logic [1:0] RPC_HOLD = 2'd0;
  localparam logic [1:0] RPC_BR   = 2'd1;
  localparam logic [1:0] RPC_JAL  = 2'd2;
  localparam logic [1:0] RPC_ALU  = 2'd3;
  // Register-file write address.
  localparam logic [1:0] RD_B     = 2'd0;
  localparam logic [1:0] RD_C     = 2'd1;
  localparam logic [1:0] RD_R7    = 2'd2;
  localparam logic [1:0] RD_ENC   = 2'd3;
  // Field override: BC_A redirects an RD_B write to rA, BC_LHI does the same
  // and substitutes imm9<<7 as write data, BC_MULTI routes C_add to the ports.
  localparam logic [1:0] BC_NONE  = 2'd0;
  localparam logic [1:0] BC_A     = 2'd1;
  localparam logic [1:0] BC_MULTI = 2'd2;
  localparam logic [1:0] BC_LHI   = 2'd3;
  // Register-file write data.
  localparam logic [1:0] M2R_MEM    = 2'd0;
  localparam logic [1:0] M2R_ALUREG = 2'd1;
  localparam logic [1:0] M2R_ALU    = 2'd2;
  localparam logic [1:0] M2R_PC     = 2'd3;
  // ALU operand B.
  localparam logic [1:0] SRCB_REGB  = 2'd0;
  localparam logic [1:0] SRCB_SEXT6 = 2'd1;
  localparam logic [1:0] SRCB_CNT   = 2'd2;
  localparam logic [1:0] SRCB_ONE   = 2'd3;
  // ALU operand A.
  localparam logic SRCA_REGA = 1'b0;
  localparam logic SRCA_PC   = 1'b1;

  typedef struct packed {
    logic [1:0] iord;
    logic [1:0] pc_sel;
    logic [1:0] reg_dst;
    logic [1:0] b_c;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_srcb;
    logic [1:0] alu_op;
    logic       alu_srca;
    logic       reg_write;
    logic       ir_write;
    logic       rega_in;
    logic       ccr_update;
    logic       enbl;
    logic       mem_write;
    logic       mem_read;
  } ctrl_out_t;

  // Conditional R-type: cond 10 needs carry set, cond 01 needs zero set.
  function automatic logic cond_skip(input logic [1:0] cond, input logic [1:0] flags);
    return ((cond == 2'b10) && !flags[1]) || ((cond == 2'b01) && !flags[0]);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational output decode: maps the current state and instruction fields
// to the datapath control bundle. MULTI outputs exist only with CTRL_LMSM_EN.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic [3:0] i_opcode,
  input  logic [1:0] i_cond,
  input  logic [1:0] i_flagreg,
  input  logic       i_zero,
  input  logic       i_out_en,
  input  logic       i_wait_done,
  output ctrl_out_t  o_ctrl
);

  logic w_skip;
  assign w_skip = cond_skip(i_cond, i_flagreg);

`ifndef CTRL_LMSM_EN
  logic w_unused;
  assign w_unused = i_out_en;
`endif

  // Per-state strobe and select decode; anything not listed stays low.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.iord       = IORD_PC;
        o_ctrl.alu_srca   = SRCA_PC;
        o_ctrl.alu_srcb   = SRCB_ONE;
        o_ctrl.alu_op     = ALU_ADD;
        o_ctrl.reg_dst    = RD_R7;
        o_ctrl.mem_to_reg = M2R_ALU;
        // Capture IR and bump R7 only once, on the last read-wait cycle.
        if (i_wait_done) begin
          o_ctrl.ir_write  = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.pc_sel    = RPC_ALU;
        end
      end
      S_EXEC_R: begin
        o_ctrl.alu_op     = (i_opcode == OP_NDU) ? ALU_NAND : ALU_ADD;
        o_ctrl.ccr_update = !w_skip;
      end
      S_EXEC_I: begin
        o_ctrl.alu_srcb   = SRCB_SEXT6;
        o_ctrl.alu_op     = ALU_ADD;
        o_ctrl.ccr_update = 1'b1;
      end
      S_WB_ALU: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = M2R_ALUREG;
        o_ctrl.reg_dst    = (i_opcode == OP_ADI) ? RD_B : RD_C;
      end
      S_MEM_ADDR: begin
        o_ctrl.rega_in  = 1'b1;
        o_ctrl.alu_srcb = SRCB_SEXT6;
        o_ctrl.alu_op   = ALU_ADD;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = IORD_ALU;
      end
      S_WB_MEM: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = M2R_MEM;
        o_ctrl.reg_dst    = RD_B;
        o_ctrl.b_c        = BC_A;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = IORD_ALU;
      end
      S_BRANCH: begin
        o_ctrl.alu_op = ALU_SUB;
        if (i_zero) o_ctrl.pc_sel = RPC_BR;
      end
      S_JAL: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = RD_B;
        o_ctrl.b_c        = BC_A;
        o_ctrl.mem_to_reg = M2R_PC;
        o_ctrl.pc_sel     = RPC_JAL;
      end
      S_LHI: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = RD_B;
        o_ctrl.b_c       = BC_LHI;
      end
`ifdef CTRL_LMSM_EN
      S_MULTI: begin
        o_ctrl.enbl    = 1'b1;
        o_ctrl.b_c     = BC_MULTI;
        o_ctrl.reg_dst = RD_ENC;
        if (i_out_en) begin
          o_ctrl.iord     = IORD_ALU;
          o_ctrl.alu_srcb = SRCB_CNT;
          o_ctrl.alu_op   = ALU_ADD;
          if (i_opcode == OP_LM) begin
            o_ctrl.mem_read   = 1'b1;
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.mem_to_reg = M2R_MEM;
          end else begin
            o_ctrl.mem_write = 1'b1;
          end
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle processor control FSM. FETCH and MEM_RD are held for MEM_RD_LAT
// cycles by a down-counter. LM/SM support (MULTI state) is built only when
// CTRL_LMSM_EN is defined; otherwise those opcodes decode as NOP.
//
// state    | meaning
// FETCH    | read IR at PC, R7 <= R7+1 on last wait cycle
// DECODE   | dispatch on opcode
// EXEC_R   | R-type ALU op (skips to FETCH on failed condition)
// EXEC_I   | ADI ALU op
// WB_ALU   | write ALU register to rC / rB
// MEM_ADDR | rB + sext6 address
// MEM_RD   | load read, MEM_RD_LAT cycles
// WB_MEM   | write load data to rA
// MEM_WR   | store write strobe
// BRANCH   | BEQ compare, R7 <= R7-1+sext6 when equal
// JAL      | rA <= R7, R7 <= R7-1+sext9
// LHI      | rA <= imm9 << 7
// MULTI    | LM/SM register stream while out_en
// HALT     | absorbing, left only by reset
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        zero,
  input  logic        overflow,
  input  logic [1:0]  flagreg,
  input  logic        out_en,
  output logic [1:0]  IorD,
  output logic [1:0]  R_pc,
  output logic [1:0]  RegDst,
  output logic [1:0]  B_C,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  aluScrb,
  output logic [1:0]  Aluop,
  output logic        aluSrca,
  output logic        RegWrite,
  output logic        IrWrite,
  output logic        regA_in,
  output logic        ccr_update,
  output logic        enbl,
  output logic        memWrite,
  output logic        memRead,
  output logic [3:0]  state_dbg
);

  localparam int WAIT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_RD_LAT - 1);

  logic [3:0]        r_state;
  logic [3:0]        w_next;
  logic [WAIT_W-1:0] r_wait;
  logic              w_wait_done;
  logic [3:0]        w_opcode;
  ctrl_out_t         w_ctrl;
  ctrl_out_t         w_out;

  assign w_opcode    = instr[15:12];
  assign w_wait_done = (r_wait == '0);

  // Flags and immediates are consumed by the datapath, not by the controller.
  logic w_unused;
`ifdef CTRL_LMSM_EN
  assign w_unused = ^{instr[11:2], overflow};
`else
  assign w_unused = ^{instr[11:2], overflow, out_en};
`endif

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_wait_done) w_next = S_DECODE;
      S_DECODE: begin
        case (w_opcode)
          OP_ADD, OP_NDU: w_next = S_EXEC_R;
          OP_ADI:         w_next = S_EXEC_I;
          OP_LHI:         w_next = S_LHI;
          OP_LW, OP_SW:   w_next = S_MEM_ADDR;
          OP_BEQ:         w_next = S_BRANCH;
          OP_JAL:         w_next = S_JAL;
`ifdef CTRL_LMSM_EN
          OP_LM, OP_SM:   w_next = S_MULTI;
`endif
          OP_HALT:        w_next = S_HALT;
          default:        w_next = S_FETCH;
        endcase
      end
      S_EXEC_R:   w_next = cond_skip(instr[1:0], flagreg) ? S_FETCH : S_WB_ALU;
      S_EXEC_I:   w_next = S_WB_ALU;
      S_WB_ALU:   w_next = S_FETCH;
      S_MEM_ADDR: w_next = (w_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (w_wait_done) w_next = S_WB_MEM;
      S_WB_MEM, S_MEM_WR, S_BRANCH, S_JAL, S_LHI: w_next = S_FETCH;
`ifdef CTRL_LMSM_EN
      S_MULTI:    w_next = out_en ? S_MULTI : S_FETCH;
`endif
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  // State register and read-latency down-counter, reloaded on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_wait  <= WAIT_LOAD;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_wait <= WAIT_LOAD;
      else if (r_wait != '0) r_wait <= r_wait - 1'b1;
    end
  end

  ctrl_decode u_decode (
    .i_state     (r_state),
    .i_opcode    (w_opcode),
    .i_cond      (instr[1:0]),
    .i_flagreg   (flagreg),
    .i_zero      (zero),
    .i_out_en    (out_en),
    .i_wait_done (w_wait_done),
    .o_ctrl      (w_ctrl)
  );

  // Outputs are forced low while reset is held so FETCH strobes start only
  // in the first cycle after release.
  assign w_out      = reset ? '0 : w_ctrl;
  assign state_dbg  = reset ? 4'd0 : r_state;
  assign IorD       = w_out.iord;
  assign R_pc       = w_out.pc_sel;
  assign RegDst     = w_out.reg_dst;
  assign B_C        = w_out.b_c;
  assign MemtoReg   = w_out.mem_to_reg;
  assign aluScrb    = w_out.alu_srcb;
  assign Aluop      = w_out.alu_op;
  assign aluSrca    = w_out.alu_srca;
  assign RegWrite   = w_out.reg_write;
  assign IrWrite    = w_out.ir_write;
  assign regA_in    = w_out.rega_in;
  assign ccr_update = w_out.ccr_update;
  assign enbl       = w_out.enbl;
  assign memWrite   = w_out.mem_write;
  assign memRead    = w_out.mem_read;

endmodule
